piradip_bit_frame_sequencer: RTL and testbench
==============================================

Name: piradip_bit_frame_sequencer

Overview:
- Frames a single-bit stream between a word-to-bit serializer and a bit-to-word deserializer.
- Accepts frame commands that give a length in bits and asserts a frame select around each frame.
- Passes exactly that many bits from the upstream bit stream to the downstream bit stream and marks the last bit.
- Pulses the align strobes after each frame so serializer residue is discarded and the deserializer's partial word is flushed.
- Sits between the stream/bit converters and a serial-interface PHY (SPI-style select/gap timing).

Parameters:
LEN_WIDTH, 16, width of cmd_len; max frame length 2^LEN_WIDTH-1 bits
SETUP_CYCLES, 2, cycles select is asserted before the first bit is allowed (0 = none)
GAP_CYCLES, 4, minimum cycles select is deasserted between frames (0 = none)
COUNT_WIDTH, 32, width of frame_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  frame command valid
cmd_ready  out  1  frame command ready
cmd_len  in  LEN_WIDTH  frame length in bits
abort  in  1  terminate the current frame
in_tvalid  in  1  upstream bit valid (from serializer)
in_tready  out  1  upstream bit ready
in_tdata  in  1  upstream bit
out_tvalid  out  1  downstream bit valid (to deserializer/PHY)
out_tready  in  1  downstream bit ready
out_tdata  out  1  downstream bit
out_tlast  out  1  last bit of frame
tx_align  out  1  one-cycle align strobe to serializer
rx_align  out  1  one-cycle align strobe to deserializer
select  out  1  frame active (chip-select, active high)
busy  out  1  state != IDLE
aborted  out  1  one-cycle pulse on FLUSH of an aborted frame
frame_count  out  COUNT_WIDTH  completed (non-aborted) frames, wraps

Behaviour:
- Clock is clk; reset is synchronous and active-high. reset has priority over all other inputs and returns the block to IDLE from any state, mid-frame included; no align pulse is generated on reset.
- Values during/after reset: select=0, busy=0, tx_align=rx_align=0, aborted=0, out_tvalid=0, out_tlast=0, in_tready=0, frame_count=0, cmd_ready=1 (IDLE).
- States: IDLE, SETUP, SHIFT, FLUSH, GAP. All outputs are decoded from registered state and counters; the datapath is a combinational pass-through.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready with cmd_len==0, the command is consumed and the block stays in IDLE (no select, no align).
  - On cmd_valid&cmd_ready with cmd_len!=0: latch remaining=cmd_len, then go to SETUP (or SHIFT if SETUP_CYCLES==0). select rises the next cycle.
- SETUP: select=1. Stays exactly SETUP_CYCLES cycles, then goes to SHIFT.
- SHIFT:
  - select=1.
  - out_tvalid=in_tvalid & ~abort, in_tready=out_tready & ~abort, out_tdata=in_tdata, out_tlast=(remaining==1).
  - Zero latency; stalls on either side are allowed.
  - A transfer is in_tvalid&out_tready&~abort. Each transfer decrements remaining.
  - A transfer with remaining==1 goes to FLUSH.
- abort=1 in SETUP or SHIFT: no transfer that cycle, go to FLUSH with the aborted flag set. abort is ignored in IDLE, FLUSH and GAP.
- FLUSH: exactly 1 cycle.
  - select=1, tx_align=rx_align=1.
  - Non-aborted frame: frame_count+=1, wrapping mod 2^COUNT_WIDTH.
  - Aborted frame: aborted=1 and frame_count is unchanged.
  - Next state is GAP (or IDLE if GAP_CYCLES==0).
- GAP: select=0. Stays exactly GAP_CYCLES cycles, then goes to IDLE.
- Outside SHIFT: in_tready=0, out_tvalid=0, out_tlast=0. cmd_ready=0 outside IDLE.
- Back-to-back: a command accepted on the first IDLE cycle after GAP is legal. Minimum frame period is 1+SETUP_CYCLES+len+1+GAP_CYCLES cycles.
- remaining is LEN_WIDTH bits and never underflows (exit happens at remaining==1).

Test Plan:
- Reset, then cmd_len=8 with source/sink always ready (defaults) -> select high 2 cycles before the first bit; 8 transfers with out_tlast only on the 8th; tx_align/rx_align high 1 cycle; select low 4 cycles; frame_count=1.
- cmd_len=5, random in_tvalid/out_tready stalls, pattern 10110 -> out_tdata sequence 10110; no transfer while either side is low; out_tlast on bit 5 only.
- cmd_len=0 -> cmd_ready stays 1, select never rises, no align pulse, frame_count unchanged.
- cmd_len=16, abort asserted after 6 transfers -> no 7th transfer; aborted and both align strobes pulse 1 cycle; frame_count unchanged; GAP observed.
- reset asserted mid-SHIFT of a 32-bit frame -> next cycle select=0, busy=0, no align pulse, frame_count=0; a new cmd_len=3 frame then completes normally.
- SETUP_CYCLES=0, GAP_CYCLES=0, two queued cmd_len=1 commands -> each frame is 3 cycles (SHIFT, FLUSH, IDLE accept); frame_count=2; frame_count wraps from 2^COUNT_WIDTH-1 to 0 when preloaded by force.

Source files
------------

// File: rtl/piradip_bit_frame_sequencer_if.sv
// Command, bit-stream and status signals of the bit frame sequencer.
// slave is the sequencer side; master is the driving/observing side.
interface piradip_bit_frame_sequencer_if #(
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [LEN_WIDTH-1:0]   cmd_len;
  logic                   abort;
  logic                   in_tvalid;
  logic                   in_tready;
  logic                   in_tdata;
  logic                   out_tvalid;
  logic                   out_tready;
  logic                   out_tdata;
  logic                   out_tlast;
  logic                   tx_align;
  logic                   rx_align;
  logic                   select;
  logic                   busy;
  logic                   aborted;
  logic [COUNT_WIDTH-1:0] frame_count;

  modport slave (
    input  cmd_valid, cmd_len, abort, in_tvalid, in_tdata, out_tready,
    output cmd_ready, in_tready, out_tvalid, out_tdata, out_tlast,
           tx_align, rx_align, select, busy, aborted, frame_count
  );

  modport master (
    output cmd_valid, cmd_len, abort, in_tvalid, in_tdata, out_tready,
    input  cmd_ready, in_tready, out_tvalid, out_tdata, out_tlast,
           tx_align, rx_align, select, busy, aborted, frame_count
  );
endinterface

// File: rtl/piradip_bit_frame_sequencer.sv
// Frames a 1-bit stream with select/setup/gap timing and align strobes after each frame.
// Zero-latency bit pass-through in SHIFT; stalls on either side, abort masks both handshakes.
module piradip_bit_frame_sequencer #(
  parameter int LEN_WIDTH    = 16,
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  piradip_bit_frame_sequencer_if.slave  bus
);
  localparam int MAXC = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_FLUSH,
    S_GAP
  } state_t;

  state_t                 r_state;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [CW-1:0]          r_cnt;
  logic                   r_aborted;
  logic [COUNT_WIDTH-1:0] r_frame_count;

  logic w_shift;
  logic w_xfer;

  assign w_shift = (r_state == S_SHIFT);
  assign w_xfer  = w_shift & bus.in_tvalid & bus.out_tready & ~bus.abort;

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.in_tready   = w_shift & bus.out_tready & ~bus.abort;
  assign bus.out_tvalid  = w_shift & bus.in_tvalid & ~bus.abort;
  assign bus.out_tdata   = bus.in_tdata;
  assign bus.out_tlast   = w_shift & (r_remaining == LEN_WIDTH'(1));
  assign bus.select      = (r_state == S_SETUP) | w_shift | (r_state == S_FLUSH);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.tx_align    = (r_state == S_FLUSH);
  assign bus.rx_align    = (r_state == S_FLUSH);
  assign bus.aborted     = (r_state == S_FLUSH) & r_aborted;
  assign bus.frame_count = r_frame_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_cnt         <= '0;
      r_aborted     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Zero-length commands are consumed without opening a frame.
          if (bus.cmd_valid && (bus.cmd_len != '0)) begin
            r_remaining <= bus.cmd_len;
            r_aborted   <= 1'b0;
            r_cnt       <= '0;
            r_state     <= (SETUP_CYCLES > 0) ? S_SETUP : S_SHIFT;
          end
        end
        S_SETUP: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_FLUSH;
          end else if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SHIFT: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_FLUSH;
          end else if (w_xfer) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (!r_aborted) begin
            r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
          end
          r_cnt   <= '0;
          r_state <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          if (r_cnt == CW'(GAP_CYCLES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piradip_bit_frame_sequencer.sv
// Directed bench: dut_a uses setup 2 / gap 4, dut_b uses no setup/gap and a 2-bit frame counter.
module tb_piradip_bit_frame_sequencer;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piradip_bit_frame_sequencer_if #(.LEN_WIDTH(LW), .COUNT_WIDTH(32)) ifa ();
  piradip_bit_frame_sequencer_if #(.LEN_WIDTH(LW), .COUNT_WIDTH(2))  ifb ();

  piradip_bit_frame_sequencer #(
    .LEN_WIDTH(LW), .SETUP_CYCLES(2), .GAP_CYCLES(4), .COUNT_WIDTH(32)
  ) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifa.slave)
  );

  piradip_bit_frame_sequencer #(
    .LEN_WIDTH(LW), .SETUP_CYCLES(0), .GAP_CYCLES(0), .COUNT_WIDTH(2)
  ) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifb.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Source bits are indexed by the number of transfers seen in the current frame.
  logic [63:0] src_pat = '0;
  int          src_i   = 0;
  logic        a_xfer;
  assign a_xfer       = ifa.out_tvalid & ifa.out_tready;
  assign ifa.in_tdata = src_pat[src_i[5:0]];
  assign ifb.in_tdata = 1'b0;

  always @(posedge clk) begin
    if (!ifa.select) src_i <= 0;
    else if (a_xfer && !rst) src_i <= src_i + 1;
  end

  int   cyc = 0, n_xfer = 0, n_last = 0, n_txal = 0, n_rxal = 0, n_abt = 0;
  int   n_gap = 0, n_rise = 0, n_viol = 0, sel_rise = 0, first_at = 0, last_at = 0, fx = 0;
  logic [63:0] bits = '0;
  logic sel_q = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      cyc   <= cyc + 1;
      sel_q <= ifa.select;
      if (ifa.select && !sel_q) begin
        n_rise   <= n_rise + 1;
        sel_rise <= cyc;
        fx       <= 0;
      end else if (a_xfer) begin
        fx     <= fx + 1;
        n_xfer <= n_xfer + 1;
        bits   <= {bits[62:0], ifa.out_tdata};
        if (fx == 0) first_at <= cyc;
        if (ifa.out_tlast) begin
          n_last  <= n_last + 1;
          last_at <= fx + 1;
        end
      end
      if (ifa.tx_align) n_txal <= n_txal + 1;
      if (ifa.rx_align) n_rxal <= n_rxal + 1;
      if (ifa.aborted)  n_abt  <= n_abt + 1;
      if (ifa.busy && !ifa.select) n_gap <= n_gap + 1;
      if ((ifa.out_tvalid && !ifa.in_tvalid) || (ifa.in_tready && !ifa.out_tready) ||
          (ifa.out_tvalid && ifa.abort) || (a_xfer != (ifa.in_tvalid && ifa.in_tready)) ||
          (ifa.out_tvalid && (ifa.out_tdata != ifa.in_tdata)))
        n_viol <= n_viol + 1;
    end
  end

  task automatic send_cmd(input logic [LW-1:0] len);
    ifa.cmd_valid = 1'b1;
    ifa.cmd_len   = len;
    @(posedge clk); #1;
    ifa.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    int n;
    n = 0;
    while (ifa.busy && n < 500) begin
      if (rnd) begin
        ifa.in_tvalid  = 1'($urandom);
        ifa.out_tready = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    ifa.in_tvalid  = 1'b1;
    ifa.out_tready = 1'b1;
    check({tag, "_done"}, 64'(n < 500), 64'(1));
  endtask

  int b_x, b_l, b_tx, b_rx, b_ab, b_g, b_r, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    ifa.cmd_valid = 0; ifa.cmd_len = '0; ifa.abort = 0; ifa.in_tvalid = 1; ifa.out_tready = 1;
    ifb.cmd_valid = 0; ifb.cmd_len = LW'(1); ifb.abort = 0; ifb.in_tvalid = 1; ifb.out_tready = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_select",   64'(ifa.select),      64'(0));
    check("rst_busy",     64'(ifa.busy),        64'(0));
    check("rst_cmdrdy",   64'(ifa.cmd_ready),   64'(1));
    check("rst_intready", 64'(ifa.in_tready),   64'(0));
    check("rst_outvalid", 64'(ifa.out_tvalid),  64'(0));
    check("rst_align",    64'({ifa.tx_align, ifa.rx_align, ifa.aborted, ifa.out_tlast}), 64'(0));
    check("rst_count",    64'(ifa.frame_count), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame of 8 bits, always-ready source and sink; bits go out LSB of src_pat first.
    src_pat = 64'hC6;
    b_x = n_xfer; b_l = n_last; b_tx = n_txal; b_rx = n_rxal; b_g = n_gap;
    send_cmd(LW'(8));
    wait_idle("f8", 1'b0);
    check("f8_xfers",   64'(n_xfer - b_x),       64'(8));
    check("f8_setup",   64'(first_at - sel_rise), 64'(2));
    check("f8_data",    bits[7:0],                64'h63);
    check("f8_nlast",   64'(n_last - b_l),        64'(1));
    check("f8_lastpos", 64'(last_at),             64'(8));
    check("f8_txalign", 64'(n_txal - b_tx),       64'(1));
    check("f8_rxalign", 64'(n_rxal - b_rx),       64'(1));
    check("f8_gap",     64'(n_gap - b_g),         64'(4));
    check("f8_count",   64'(ifa.frame_count),     64'(1));

    // Frame of 5 bits (1,0,1,1,0) with random stalls on both sides.
    src_pat = 64'h0D;
    b_x = n_xfer; b_l = n_last;
    send_cmd(LW'(5));
    wait_idle("f5", 1'b1);
    check("f5_xfers",   64'(n_xfer - b_x),   64'(5));
    check("f5_data",    64'(bits[4:0]),      64'(5'b10110));
    check("f5_nlast",   64'(n_last - b_l),   64'(1));
    check("f5_lastpos", 64'(last_at),        64'(5));
    check("f5_count",   64'(ifa.frame_count), 64'(2));

    // Zero-length command is consumed without a frame.
    b_r = n_rise; b_tx = n_txal;
    send_cmd(LW'(0));
    check("z_busy",   64'(ifa.busy),      64'(0));
    check("z_cmdrdy", 64'(ifa.cmd_ready), 64'(1));
    repeat (6) @(posedge clk);
    #1;
    check("z_select", 64'(n_rise - b_r),    64'(0));
    check("z_align",  64'(n_txal - b_tx),   64'(0));
    check("z_count",  64'(ifa.frame_count), 64'(2));

    // Abort after six transfers of a 16-bit frame.
    b_x = n_xfer; b_l = n_last; b_tx = n_txal; b_rx = n_rxal; b_ab = n_abt; b_g = n_gap;
    send_cmd(LW'(16));
    n = 0;
    while ((n_xfer - b_x) < 6 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ab_reach6", 64'(n_xfer - b_x), 64'(6));
    ifa.abort = 1'b1;
    #1;
    check("ab_outvalid", 64'(ifa.out_tvalid), 64'(0));
    check("ab_intready", 64'(ifa.in_tready),  64'(0));
    @(posedge clk); #1;
    ifa.abort = 1'b0;
    check("ab_pulse",  64'({ifa.aborted, ifa.tx_align, ifa.rx_align, ifa.select}), 64'(4'b1111));
    wait_idle("ab", 1'b0);
    check("ab_xfers",  64'(n_xfer - b_x),   64'(6));
    check("ab_nlast",  64'(n_last - b_l),   64'(0));
    check("ab_npulse", 64'(n_abt - b_ab),   64'(1));
    check("ab_align",  64'((n_txal - b_tx) + (n_rxal - b_rx)), 64'(2));
    check("ab_gap",    64'(n_gap - b_g),    64'(4));
    check("ab_count",  64'(ifa.frame_count), 64'(2));

    // Reset in the middle of a 32-bit frame, then a 3-bit frame.
    send_cmd(LW'(32));
    repeat (10) @(posedge clk);
    #1;
    check("rs_inshift", 64'(ifa.out_tvalid), 64'(1));
    b_tx = n_txal;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rs_select", 64'(ifa.select),      64'(0));
    check("rs_busy",   64'(ifa.busy),        64'(0));
    check("rs_align",  64'(ifa.tx_align),    64'(0));
    check("rs_count",  64'(ifa.frame_count), 64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rs_noalign", 64'(n_txal - b_tx), 64'(0));
    src_pat = 64'h5;
    b_x = n_xfer;
    send_cmd(LW'(3));
    wait_idle("rs3", 1'b0);
    check("rs3_xfers",   64'(n_xfer - b_x),    64'(3));
    check("rs3_data",    64'(bits[2:0]),       64'(3'b101));
    check("rs3_lastpos", 64'(last_at),         64'(3));
    check("rs3_count",   64'(ifa.frame_count), 64'(1));

    // No setup/gap: back-to-back 1-bit frames every 3 cycles, 2-bit counter wraps.
    check("b_idle", 64'({ifb.cmd_ready, ifb.frame_count}), 64'(3'b100));
    for (int k = 1; k <= 5; k++) begin
      ifb.cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("b_shift", 64'({ifb.out_tvalid, ifb.out_tlast, ifb.select, ifb.cmd_ready}), 64'(4'b1110));
      @(posedge clk); #1;
      check("b_flush", 64'({ifb.tx_align, ifb.rx_align, ifb.out_tvalid}), 64'(3'b110));
      @(posedge clk); #1;
      check("b_accept", 64'(ifb.cmd_ready),   64'(1));
      check("b_count",  64'(ifb.frame_count), 64'(k % 4));
    end
    ifb.cmd_valid = 1'b0;

    check("handshake_rules", 64'(n_viol), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
